turf_wb_initiator: RTL and testbench
====================================

TURF_WB_INITIATOR -- requirements
Module: turf_wb_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, bus cycles without termination before abort (range 2..65535).
REQ-002 Parameter MAX_RETRIES, default 3, re-issues allowed after rty_i before giving up (range 0..15).
REQ-003 clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert by upstream.
REQ-005 cmd_valid_i  in  1 / cmd_ready_o  out  1  command handshake.
REQ-006 cmd_we_i  in  1 / cmd_adr_i  in  28 / cmd_dat_i  in  32 / cmd_sel_i  in  4  command write flag, address, write data, byte selects.
REQ-007 rsp_valid_o  out  1 / rsp_ready_i  in  1  response handshake.
REQ-008 rsp_dat_o  out  32 / rsp_status_o  out  2  read data; status 00 ok, 01 err, 10 retries exhausted, 11 timeout.
REQ-009 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each; wb_adr_o  out  28; wb_dat_o  out  32; wb_sel_o  out  4  WISHBONE host outputs.
REQ-010 wb_dat_i  in  32; wb_ack_i, wb_err_i, wb_rty_i  in  1 each  WISHBONE host inputs.

Function
REQ-011 FSM states IDLE, BUS, GAP, RESP; only one transaction outstanding.
REQ-012 cmd_ready_o SHALL be 1 in IDLE only.
REQ-013 IDLE: cmd_valid_i&cmd_ready_o latches we/adr/dat/sel into registers, clears retry and timeout counters, -> BUS.
REQ-014 wb_cyc_o and wb_stb_o SHALL be 1 exactly while in BUS; asserted first the cycle after command acceptance.
REQ-015 wb_we_o/adr_o/dat_o/sel_o SHALL be driven from latched registers, stable for whole BUS period.
REQ-016 BUS termination priority when simultaneous: ack > err > rty > timeout.
REQ-017 BUS, wb_ack_i=1: rsp_dat_o <= wb_dat_i if read, 0 if write; status 00; -> RESP.
REQ-018 BUS, wb_err_i=1: rsp_dat_o <= 0; status 01; -> RESP.
REQ-019 BUS, wb_rty_i=1 and retry count < MAX_RETRIES: increment retry count, -> GAP; cyc/stb deassert one cycle, then GAP -> BUS with timeout counter cleared.
REQ-020 BUS, wb_rty_i=1 and retry count = MAX_RETRIES: rsp_dat_o <= 0; status 10; -> RESP.
REQ-021 Timeout counter (16 bit) increments each BUS cycle without termination; at count TIMEOUT_CYCLES-1 with no termination: status 11, rsp_dat_o <= 0, -> RESP (cyc high exactly TIMEOUT_CYCLES cycles).
REQ-022 RESP: rsp_valid_o=1, rsp_dat_o/rsp_status_o held; on rsp_ready_i=1 -> IDLE.
REQ-023 Back-to-back: next command accepted earliest the cycle after response handshake.
REQ-024 Terminations (ack/err/rty) arriving outside BUS SHALL be ignored.

Reset
REQ-025 While rst_i=0: state IDLE; all outputs 0 except cmd_ready_o, which is 0 during reset and 1 the first cycle after release.
REQ-026 Reset mid-transaction SHALL drop wb_cyc_o/wb_stb_o immediately (asynchronous) and discard the transaction; no response generated.
REQ-027 Counters and latched command registers reset to 0.

Verification
REQ-028 Read adr 0x0004010, target acks 2 cycles after stb with 0xDEADBEEF -> cyc high 3 cycles, rsp_dat_o=0xDEADBEEF, status 00.
REQ-029 Write adr 0x0010004, dat 0x12345678, sel 0xC, ack same cycle stb seen -> wb_we_o=1, wb_sel_o=0xC, rsp_dat_o=0, status 00.
REQ-030 MAX_RETRIES=3, target returns rty every attempt -> 4 BUS periods separated by 1-cycle gaps, status 10.
REQ-031 TIMEOUT_CYCLES=16, target silent -> cyc high exactly 16 cycles, status 11; ack+err same cycle -> status 00.
REQ-032 rst_i pulled low during BUS -> wb_cyc_o=0 same cycle, rsp_valid_o=0; after release cmd_ready_o=1 and new command completes normally.
REQ-033 rsp_ready_i held 0 for 10 cycles -> rsp_valid_o and data held, cmd_ready_o=0 throughout; new command accepted only after handshake.

Source files
------------

// File: rtl/turf_wb_initiator.sv
// Single-outstanding WISHBONE classic host: takes one command, runs the bus
// cycle with retry and timeout handling, then presents a held response.
module turf_wb_initiator #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [27:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic [1:0]  rsp_status_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [27:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i
);

    typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RTY_MAX  = 4'(MAX_RETRIES);

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_ERR  = 2'b01;
    localparam logic [1:0] ST_RTY  = 2'b10;
    localparam logic [1:0] ST_TMO  = 2'b11;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [27:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  retry_q, retry_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]  rsp_st_q, rsp_st_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            retry_q   <= '0;
            tmo_q     <= '0;
            rsp_dat_q <= '0;
            rsp_st_q  <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_st_q  <= rsp_st_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        rsp_dat_d = rsp_dat_q;
        rsp_st_d  = rsp_st_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    sel_d   = cmd_sel_i;
                    retry_d = '0;
                    tmo_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Terminations are resolved ack > err > rty > timeout.
                if (wb_ack_i) begin
                    rsp_dat_d = we_q ? 32'h0 : wb_dat_i;
                    rsp_st_d  = ST_OK;
                    state_d   = RESP;
                end else if (wb_err_i) begin
                    rsp_dat_d = '0;
                    rsp_st_d  = ST_ERR;
                    state_d   = RESP;
                end else if (wb_rty_i) begin
                    if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + 4'd1;
                        state_d = GAP;
                    end else begin
                        rsp_dat_d = '0;
                        rsp_st_d  = ST_RTY;
                        state_d   = RESP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    rsp_dat_d = '0;
                    rsp_st_d  = ST_TMO;
                    state_d   = RESP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            GAP: begin
                tmo_d   = '0;
                state_d = BUS;
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with rst_i keeps cmd_ready low while reset is held.
    assign cmd_ready_o  = (state_q == IDLE) && rst_i;
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_st_q;
    assign wb_cyc_o     = (state_q == BUS);
    assign wb_stb_o     = (state_q == BUS);
    assign wb_we_o      = we_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;

endmodule

// File: tb/tb_turf_wb_initiator.sv
// Randomized bench: a scripted WISHBONE target plus a transaction-level model
// predicting response, bus-cycle count and number of bus periods.
module tb_turf_wb_initiator;

    localparam int TMO  = 16;
    localparam int MAXR = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [27:0] cmd_adr_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic [1:0]  rsp_status_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [27:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

    turf_wb_initiator #(.TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_total = 0;

    // Target script per bus attempt: mask {rty,err,ack} raised in cycle index pd.
    logic [2:0]  pm [4];
    int          pd [4];
    logic [31:0] cur_rd;
    logic        cur_we;
    logic [27:0] cur_adr;
    logic [31:0] cur_dat;
    logic [3:0]  cur_sel;
    logic [31:0] exp_dat;
    logic [1:0]  exp_st;
    int          exp_cyc, exp_per;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model(input logic we, input logic [31:0] rd,
                                  output logic [31:0] dat, output logic [1:0] st,
                                  output int cyc, output int per);
        cyc = 0; per = 0; dat = '0; st = 2'b11;
        for (int k = 0; k < 4; k++) begin
            per++;
            if (pm[k] == 3'b000 || pd[k] >= TMO) begin
                cyc += TMO; st = 2'b11; return;
            end
            cyc += pd[k] + 1;
            if (pm[k][0]) begin st = 2'b00; dat = we ? 32'h0 : rd; return; end
            if (pm[k][1]) begin st = 2'b01; return; end
            if (k == MAXR) begin st = 2'b10; return; end
        end
    endfunction

    // Target: answers during BUS from the script, drives random noise otherwise.
    int att = 0, cnt = 0;
    bit in_bus = 0;
    always @(negedge clk_i) begin
        if (!rst_i || (cmd_valid_i && cmd_ready_o)) begin
            att = 0; cnt = 0; in_bus = 0;
        end
        if (wb_cyc_o && att < 4) begin
            {wb_rty_i, wb_err_i, wb_ack_i} = (cnt == pd[att]) ? pm[att] : 3'b000;
            wb_dat_i = cur_rd;
            cnt++;
            in_bus = 1;
        end else begin
            if (in_bus) begin att++; cnt = 0; in_bus = 0; end
            {wb_rty_i, wb_err_i, wb_ack_i} = 3'($urandom_range(0, 7));
            wb_dat_i = $urandom;
        end
    end

    // Compare process: per-cycle bus/response checks, per-transaction totals.
    int  cyc_cnt = 0, per_cnt = 0, low_run = 0;
    bit  prev_cyc = 0;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            cyc_cnt = 0; per_cnt = 0; low_run = 0; prev_cyc = 0;
        end else begin
            chk("stb_eq_cyc", 32'(wb_stb_o), 32'(wb_cyc_o));
            if (wb_cyc_o) begin
                chk("wb_we", 32'(wb_we_o), 32'(cur_we));
                chk("wb_adr", 32'(wb_adr_o), 32'(cur_adr));
                chk("wb_dat", wb_dat_o, cur_dat);
                chk("wb_sel", 32'(wb_sel_o), 32'(cur_sel));
                if (!prev_cyc && per_cnt > 0) chk("gap_len", 32'(low_run), 32'd1);
                if (!prev_cyc) per_cnt++;
                cyc_cnt++;
                low_run = 0;
            end else begin
                low_run++;
            end
            if (wb_cyc_o || rsp_valid_o) chk("cmd_ready_busy", 32'(cmd_ready_o), 32'd0);
            if (rsp_valid_o) begin
                chk("rsp_dat", rsp_dat_o, exp_dat);
                chk("rsp_status", 32'(rsp_status_o), 32'(exp_st));
                if (rsp_ready_i) begin
                    chk("cyc_cycles", 32'(cyc_cnt), 32'(exp_cyc));
                    chk("bus_periods", 32'(per_cnt), 32'(exp_per));
                end
            end
            prev_cyc = wb_cyc_o;
            if (cmd_valid_i && cmd_ready_o) begin
                cyc_cnt = 0; per_cnt = 0; low_run = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic we, input logic [27:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] rd);
        int k;
        cur_we = we; cur_adr = adr; cur_dat = dat; cur_sel = sel; cur_rd = rd;
        model(we, rd, exp_dat, exp_st, exp_cyc, exp_per);
        cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
        cmd_valid_i = 1'b1;
        k = 0;
        @(negedge clk_i);
        while (!cmd_ready_o && k < 50) begin @(negedge clk_i); k++; end
        if (k >= 50) chk("accept_timeout", 32'(cmd_ready_o), 32'd1);
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic finish(input int stall);
        int k;
        k = 0;
        while (!rsp_valid_o && k < 300) begin step(); k++; end
        if (k >= 300) chk("rsp_timeout", 32'(rsp_valid_o), 32'd1);
        repeat (stall) step();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk("ready_after_rsp", 32'(cmd_ready_o), 32'd1);
        chk("valid_after_rsp", 32'(rsp_valid_o), 32'd0);
    endtask

    task automatic plan1(input logic [2:0] m, input int d);
        for (int k = 0; k < 4; k++) begin pm[k] = m; pd[k] = d; end
    endtask

    logic [31:0] md;
    logic [1:0]  ms;
    int          mc, mp;

    initial begin
        plan1(3'b001, 0);
        cur_rd = '0; cur_we = 0; cur_adr = '0; cur_dat = '0; cur_sel = '0;
        exp_dat = '0; exp_st = '0; exp_cyc = 0; exp_per = 0;
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_dat", rsp_dat_o, 32'd0);
        chk("rst_wb_adr", 32'(wb_adr_o), 32'd0);
        chk("rst_wb_dat", wb_dat_o, 32'd0);
        chk("rst_wb_misc", {25'd0, wb_we_o, wb_sel_o, rsp_status_o}, 32'd0);
        step();
        rst_i = 1'b1;
        step();
        chk("ready_after_rst", 32'(cmd_ready_o), 32'd1);

        // Model pins against hand-computed values.
        plan1(3'b001, 2);
        model(1'b0, 32'hDEADBEEF, md, ms, mc, mp);
        chk("pin_rd_cyc", 32'(mc), 32'd3);
        chk("pin_rd_dat", md, 32'hDEADBEEF);
        plan1(3'b100, 1);
        model(1'b0, 32'h1, md, ms, mc, mp);
        chk("pin_rty_per", 32'(mp), 32'd4);
        chk("pin_rty_st", 32'(ms), 32'd2);
        chk("pin_rty_cyc", 32'(mc), 32'd8);
        plan1(3'b000, 0);
        model(1'b1, 32'h1, md, ms, mc, mp);
        chk("pin_tmo_cyc", 32'(mc), 32'd16);
        chk("pin_tmo_st", 32'(ms), 32'd3);

        // Read with ack two cycles after strobe.
        plan1(3'b001, 2);
        issue(1'b0, 28'h0004010, 32'h0, 4'hF, 32'hDEADBEEF);
        finish(0);
        // Write acked in the first strobe cycle.
        plan1(3'b001, 0);
        issue(1'b1, 28'h0010004, 32'h12345678, 4'hC, 32'hCAFEF00D);
        finish(0);
        // Retry on every attempt.
        plan1(3'b100, 1);
        issue(1'b0, 28'h0000100, 32'h0, 4'h3, 32'h5A5A5A5A);
        finish(1);
        // Silent target: timeout.
        plan1(3'b000, 0);
        issue(1'b1, 28'h0ABCDEF, 32'h01020304, 4'h1, 32'h0);
        finish(0);
        // ack and err together: ack wins.
        plan1(3'b011, 3);
        issue(1'b0, 28'h0000040, 32'h0, 4'hF, 32'h13572468);
        finish(0);
        // Termination in the same cycle the timeout would expire.
        plan1(3'b010, TMO - 1);
        issue(1'b0, 28'h0000044, 32'h0, 4'hF, 32'h1);
        finish(0);
        // Long response stall.
        plan1(3'b001, 1);
        issue(1'b0, 28'h0000080, 32'h0, 4'hF, 32'h0BADF00D);
        finish(10);

        // Reset in the middle of a bus period.
        plan1(3'b000, 0);
        issue(1'b0, 28'h0000200, 32'h0, 4'hF, 32'h0);
        repeat (4) step();
        chk("bus_before_rst", 32'(wb_cyc_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("rst_drops_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_drops_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_no_rsp", 32'(rsp_valid_o), 32'd0);
        chk("rst_ready_low", 32'(cmd_ready_o), 32'd0);
        step();
        step();
        rst_i = 1'b1;
        step();
        chk("ready_after_rel", 32'(cmd_ready_o), 32'd1);
        chk("no_rsp_after_rel", 32'(rsp_valid_o), 32'd0);
        plan1(3'b001, 0);
        issue(1'b0, 28'h0000300, 32'h0, 4'hF, 32'h76543210);
        finish(0);

        // Random transactions.
        for (int t = 0; t < 60; t++) begin
            for (int k = 0; k < 4; k++) begin
                int r;
                r = $urandom_range(0, 9);
                case (r)
                    0, 1, 2: pm[k] = 3'b001;
                    3:       pm[k] = 3'b010;
                    4, 5, 6: pm[k] = 3'b100;
                    7:       pm[k] = 3'($urandom_range(1, 7));
                    8:       pm[k] = 3'b000;
                    default: pm[k] = 3'b101;
                endcase
                pd[k] = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
            end
            issue(1'($urandom), 28'($urandom), $urandom, 4'($urandom), $urandom);
            finish($urandom_range(0, 3));
        end

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
